// File: rtl/keypad_scan16.sv
// keypad_scan16: scans a 4x4 hex matrix keypad, debounces presses and shifts each accepted
// digit into a 32-bit entry register. Define KEYPAD_AUTOREPEAT_EN for auto-repeat while held.
module keypad_scan16 #(
    parameter int SCAN_DIV     = 13,
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        clr,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [31:0] o_data,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic        o_pending
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] DEB_LIMIT = 4'(DEB_TICKS);

    if (SCAN_DIV < 1 || DEB_TICKS < 1 || DEB_TICKS > 15 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scan16: need SCAN_DIV >= 1, DEB_TICKS in 1..15, REPEAT_TICKS >= 1");
    end

    state_t              state, state_n;
    logic [3:0]          col_meta, col_s;
    logic [SCAN_DIV-1:0] prescaler;
    logic                tick;
    logic [1:0]          row_idx, row_idx_n;
    logic [3:0]          pattern, pattern_n;
    logic [3:0]          deb_cnt, deb_cnt_n;
    logic [3:0]          rel_cnt, rel_cnt_n;
    logic                col_valid;
    logic                accept;
    logic [3:0]          code_n;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               RPT_W     = $clog2(REPEAT_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_LIMIT = RPT_W'(REPEAT_TICKS);
    logic [RPT_W-1:0]            rpt_cnt, rpt_cnt_n;
`endif

    function automatic logic [1:0] col_of(input logic [3:0] pat);
        logic [1:0] idx;
        case (pat)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Exactly one low column is a key; none or several (ghosting) count as no key.
    always_comb begin
        case (col_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: col_valid = 1'b1;
            default:                            col_valid = 1'b0;
        endcase
    end

    assign tick    = &prescaler;
    assign row_out = ~(4'b0001 << row_idx);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // the synchronizer resets to all-ones, the idle level of the pulled-up columns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta  <= 4'hF;
            col_s     <= 4'hF;
            prescaler <= '0;
        end else begin
            col_meta  <= col_in;
            col_s     <= col_meta;
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            pattern <= 4'hF;
            deb_cnt <= 4'd0;
            rel_cnt <= 4'd0;
        end else begin
            state   <= state_n;
            row_idx <= row_idx_n;
            pattern <= pattern_n;
            deb_cnt <= deb_cnt_n;
            rel_cnt <= rel_cnt_n;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rpt_cnt <= '0;
        else       rpt_cnt <= rpt_cnt_n;
    end
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        pattern_n = pattern;
        deb_cnt_n = deb_cnt;
        rel_cnt_n = rel_cnt;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_n = rpt_cnt;
`endif
        case (state)
            SCAN: begin
                if (tick) begin
                    if (col_valid) begin
                        pattern_n = col_s;
                        deb_cnt_n = 4'd1;
                        state_n   = (DEB_LIMIT == 4'd1) ? PRESSED : DEBOUNCE;
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (col_s == pattern) begin
                        deb_cnt_n = deb_cnt + 4'd1;
                        if (deb_cnt_n == DEB_LIMIT) state_n = PRESSED;
                    end else begin
                        state_n   = SCAN;
                        row_idx_n = row_idx + 2'd1;
                    end
                end
            end
            PRESSED: begin
                state_n   = WAIT_RELEASE;
                rel_cnt_n = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_cnt_n = '0;
`endif
            end
            WAIT_RELEASE: begin
                // The row stays held, so keys on other rows or columns are simply not seen.
                if (tick) begin
                    if (col_s == 4'hF) begin
                        rel_cnt_n = rel_cnt + 4'd1;
                        if (rel_cnt_n == DEB_LIMIT) begin
                            state_n   = SCAN;
                            row_idx_n = row_idx + 2'd1;
                        end
                    end else begin
                        rel_cnt_n = 4'd0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (col_s == pattern) begin
                        rpt_cnt_n = rpt_cnt + 1'b1;
                        if (rpt_cnt_n == RPT_LIMIT) state_n = PRESSED;
                    end else begin
                        rpt_cnt_n = '0;
                    end
`endif
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // Outputs load on the transition into PRESSED, so they are all valid during that clock.
    assign accept = (state_n == PRESSED);
    assign code_n = {row_idx_n, col_of(pattern_n)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data      <= 32'h0;
            o_key       <= 4'h0;
            o_key_valid <= 1'b0;
            o_pending   <= 1'b0;
        end else begin
            o_key_valid <= accept;
            if (accept) begin
                o_key     <= code_n;
                o_data    <= clr ? {28'h0, code_n} : {o_data[27:0], code_n};
                o_pending <= 1'b1;
            end else begin
                if (clr) o_data    <= 32'h0;
                if (cs)  o_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/keypad_scan16.md
Name: keypad_scan16

Overview:
- Input-side counterpart of the 8-digit hex display driver: scans a 4x4 hex matrix keypad and debounces key presses.
- Shifts each accepted hex digit into a 32-bit entry register, the same word format the display consumes (newest digit in [3:0]).
- Sits on the CPU peripheral bus next to the display; the CPU reads o_data and o_pending, and strobes cs to acknowledge.

Parameters:
- SCAN_DIV, 13: prescaler width; scan tick every 2^SCAN_DIV clocks.
- DEB_TICKS, 4: consecutive matching ticks needed to accept a press or release (range 1..15).
- REPEAT_TICKS, 64: auto-repeat interval in ticks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cs  in  1  CPU acknowledge strobe; clears o_pending
- clr  in  1  synchronous clear of o_data
- col_in  in  4  keypad columns, active-low, asynchronous, externally pulled up
- row_out  out  4  keypad rows, active-low one-hot drive
- o_data  out  32  entry register, newest digit in [3:0]
- o_key  out  4  code of the last accepted key
- o_key_valid  out  1  one-clock pulse per accepted key event
- o_pending  out  1  a key was accepted since the last cs

Behaviour:
- Reset values: row_out=4'b1110, o_data=0, o_key=0, o_key_valid=0, o_pending=0, state=SCAN, all counters 0.
- col_in passes through a 2-flop synchronizer; all decisions use the synchronized value colS.
- Prescaler counts freely and wraps. tick is high for one clock when the prescaler is all-ones. All FSM sampling happens only on tick.
- Key code = row_idx*4 + col_idx, 4 bits.
- A colS pattern is valid only when exactly one bit is low. Zero or multiple lows are treated as no key (ghost rejection).
- SCAN state, on each tick:
  - Valid pattern: latch row_idx and pattern, set deb_cnt=1, go to DEBOUNCE. If DEB_TICKS=1, go directly to PRESSED.
  - Otherwise: row_idx=row_idx+1 (wraps 3->0) and row_out rotates.
- DEBOUNCE (row held), on each tick:
  - Same pattern: deb_cnt++. When deb_cnt reaches DEB_TICKS, go to PRESSED.
  - Different pattern: go to SCAN and advance the row.
- PRESSED (exactly one clock):
  - o_key_valid=1, o_key=code, o_data<={o_data[27:0],code}, o_pending=1.
  - Next state WAIT_RELEASE with rel_cnt=0.
- WAIT_RELEASE (row held), on each tick:
  - colS==4'hF: rel_cnt++; otherwise rel_cnt=0.
  - When rel_cnt reaches DEB_TICKS, go to SCAN and advance the row.
  - Other keys pressed meanwhile are ignored.
- Press latency: o_key_valid asserts 1 clock after the DEB_TICKS-th matching tick.
- clr and a key shift in the same cycle: o_data={28'h0,code}.
- clr alone: o_data=0.
- cs and a key accept in the same cycle: o_pending stays 1.
- cs alone: o_pending=0.
- o_key holds its value until the next accepted key.
- Reset mid-operation returns everything to reset values; no key event is emitted.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined:
  - WAIT_RELEASE also counts ticks while the same valid pattern is held (rpt_cnt, reset on entry).
  - When rpt_cnt reaches REPEAT_TICKS, the block re-enters PRESSED (new event, shift, pending), then returns to WAIT_RELEASE with rpt_cnt=0.
  - A pattern change or release resets rpt_cnt.
- Undefined: exactly one event per physical press; REPEAT_TICKS is unused and no rpt_cnt logic is synthesized.

Test Plan (SCAN_DIV=4, i.e. tick every 16 clocks; DEB_TICKS=4):
- Reset, no key -> row_out cycles 1110,1101,1011,0111,1110 every 16 clocks; o_data=0, o_pending=0.
- Hold column 2 low while row 1 is driven, clean press -> one o_key_valid pulse on the clock after the 4th matching tick, o_key=4'h6, o_data=32'h6, o_pending=1; release for 4 ticks -> row advances to 2.
- Press keys 1,2,3,A in sequence -> o_data=32'h123A; cs pulse -> o_pending=0, o_data unchanged.
- Bounce: column low for 2 ticks, high for 1, low for 4 -> exactly one event; column low for 3 ticks only -> no event.
- Two columns low on the same row -> no event and the scan continues; clr coinciding with a press of key 5 while o_data=32'hFFFF -> o_data=32'h5.
- KEYPAD_AUTOREPEAT_EN defined with REPEAT_TICKS=8: hold key 9 for 4+8*3 ticks -> 4 events and o_data=32'h9999; without the macro -> 1 event.
